// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the buffered UART receive path.
// Optional build macro: UART_RX_FIFO_IRQ_EN adds the registered irq output.
// Default register addresses; the SoC top may predefine these.
`ifndef UART_RX_ADDR
`define UART_RX_ADDR 32'h0200_0008
`endif
`ifndef UART_LSR_ADDR
`define UART_LSR_ADDR 32'h0200_0014
`endif

package uart_rx_fifo_pkg;

  // LSR bit positions shared with the SoC register map.
  localparam int unsigned LsrDr   = 0;
  localparam int unsigned LsrOe   = 1;
  localparam int unsigned LsrThre = 5;
  localparam int unsigned LsrTemt = 6;

  typedef enum logic {StIdle, StResp} bus_state_e;

  function automatic logic [7:0] lsr_byte(input logic tx_busy, input logic overrun,
                                          input logic not_empty);
    logic [7:0] lsr;
    lsr          = 8'h00;
    lsr[LsrDr]   = not_empty;
    lsr[LsrOe]   = overrun;
    lsr[LsrThre] = !tx_busy;
    lsr[LsrTemt] = !tx_busy;
    return lsr;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// CPU memory-bus handshake as seen by the UART receive registers.
interface uart_rx_fifo_if;
  logic        valid;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic        is_valid;

  modport master (output valid, addr, wstrb, input rdata, ready, is_valid);
  modport slave  (input valid, addr, wstrb, output rdata, ready, is_valid);
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous FIFO (sync_fifo): storage, wrapping pointers and occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             empty, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_q];
  assign count   = count_q;

  // Occupancy after this cycle's accepted push/pop.
  always_comb begin
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointers and count; pointers wrap at DEPTH by width.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// Buffered UART RX path: FIFO for received bytes, RX data and LSR registers
// on the CPU bus, sticky overrun flag. Optional UART_RX_FIFO_IRQ_EN adds irq.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] RX_ADDR   = `UART_RX_ADDR,
  parameter logic [31:0] LSR_ADDR  = `UART_LSR_ADDR,
  parameter int unsigned IRQ_LEVEL = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic               tx_busy,
  uart_rx_fifo_if.slave      bus
`ifdef UART_RX_FIFO_IRQ_EN
  ,
  output logic               irq
`endif
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two in 2..256");
  end
  if (IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_bad_irq_level
    $error("IRQ_LEVEL must be in 1..DEPTH");
  end

  bus_state_e    state_q, state_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          overrun_q, overrun_d;
  logic          hit_rx, hit_lsr, sel, pop, ovr_event, full, empty;
  logic [7:0]    head;
  logic [CW-1:0] fifo_count;

  assign hit_rx       = (bus.addr == RX_ADDR);
  assign hit_lsr      = (bus.addr == LSR_ADDR);
  assign bus.is_valid = bus.valid && (hit_rx || hit_lsr);
  assign sel          = bus.valid && !bus.ready && !(|bus.wstrb) && (hit_rx || hit_lsr);
  assign empty        = (fifo_count == '0);
  assign pop          = sel && hit_rx && !empty;
  // Dropped byte: full and no pop frees a slot this cycle.
  assign ovr_event    = rx_valid && full && !pop;
  assign bus.ready    = (state_q == StResp);
  assign bus.rdata    = rdata_q;

  uart_rx_fifo_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (rx_valid),
    .wdata  (rx_data),
    .pop    (pop),
    .head   (head),
    .full   (full),
    .count  (fifo_count)
  );

  // Bus response FSM and read-data mux; rdata holds between completions.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (sel) begin
          state_d = StResp;
          if (hit_rx) begin
            rdata_d = empty ? 32'hFFFF_FFFF : {24'b0, head};
          end else begin
            rdata_d = {16'b0, lsr_byte(tx_busy, overrun_q, !empty), 8'b0};
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Sticky overrun: a new drop wins over the clearing LSR read.
  always_comb begin
    overrun_d = overrun_q;
    if (ovr_event) begin
      overrun_d = 1'b1;
    end else if (sel && !hit_rx && hit_lsr) begin
      overrun_d = 1'b0;
    end
  end

  // Bus state, read data and overrun registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      rdata_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef UART_RX_FIFO_IRQ_EN
  logic irq_q;

  // Level interrupt, registered from current occupancy and overrun.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (fifo_count >= CW'(IRQ_LEVEL)) || overrun_q;
    end
  end

  assign irq = irq_q;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed cases plus random traffic
// against a queue-based model of the receive buffer and its registers.
module tb_uart_rx_fifo;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned IRQ_LEVEL = 4;
  localparam logic [31:0] RX_A      = 32'h1000_0000;
  localparam logic [31:0] LSR_A     = 32'h1000_0014;

  logic       clk      = 1'b0;
  logic       resetn   = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       tx_busy  = 1'b0;
`ifdef UART_RX_FIFO_IRQ_EN
  logic       irq;
`endif

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(
    .DEPTH     (DEPTH),
    .RX_ADDR   (RX_A),
    .LSR_ADDR  (LSR_A),
    .IRQ_LEVEL (IRQ_LEVEL)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_busy  (tx_busy),
    .bus      (bus)
`ifdef UART_RX_FIFO_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] mq[$];
  bit         m_ovr    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: a byte arriving while full (and not popped) is lost and flags overrun.
  task automatic model_push(input logic [7:0] b);
    if (mq.size() < DEPTH) mq.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
    model_push(b);
  endtask

  task automatic bus_read(input logic [31:0] a, input logic do_push, input logic [7:0] b,
                          input string tag);
    logic [31:0] exp;
    logic [7:0]  lsr;
    bit          popped;
    bit          lost;
    popped = 1'b0;
    if (a == RX_A) begin
      if (mq.size() == 0) exp = 32'hFFFF_FFFF;
      else begin
        exp    = {24'b0, mq[0]};
        popped = 1'b1;
      end
    end else begin
      lsr = {1'b0, !tx_busy, !tx_busy, 3'b000, m_ovr, mq.size() != 0};
      exp = {16'b0, lsr, 8'b0};
    end
    bus.valid = 1'b1;
    bus.addr  = a;
    bus.wstrb = 4'h0;
    rx_valid  = do_push;
    rx_data   = b;
    #1;
    check({tag, ".pre_ready"}, {31'b0, bus.ready}, 32'd0);
    check({tag, ".is_valid"}, {31'b0, bus.is_valid}, 32'd1);
    step();
    rx_valid = 1'b0;
    check({tag, ".ready"}, {31'b0, bus.ready}, 32'd1);
    check({tag, ".rdata"}, bus.rdata, exp);
    step();
    bus.valid = 1'b0;
    check({tag, ".ready_pulse"}, {31'b0, bus.ready}, 32'd0);
    if (popped) void'(mq.pop_front());
    lost = 1'b0;
    if (do_push) begin
      if (mq.size() < DEPTH) mq.push_back(b);
      else lost = 1'b1;
    end
    if (a == LSR_A) m_ovr = lost;
    else if (lost) m_ovr = 1'b1;
  endtask

`ifdef UART_RX_FIFO_IRQ_EN
  task automatic check_irq(input string tag);
    check(tag, {31'b0, irq}, {31'b0, (mq.size() >= IRQ_LEVEL) || m_ovr});
  endtask
`endif

  initial begin
    bus.valid = 1'b0;
    bus.addr  = 32'h0;
    bus.wstrb = 4'h0;
    #12;
    check("reset.ready", {31'b0, bus.ready}, 32'd0);
    check("reset.rdata", bus.rdata, 32'd0);
    #3 resetn = 1'b1;
    step();

    // LSR after reset: THRE and TEMT only.
    bus_read(LSR_A, 1'b0, 8'h00, "lsr_reset");
    check("lsr_reset.const", bus.rdata, 32'h0000_6000);

    // Two bytes out in order, then the empty marker.
    push_byte(8'h41);
    push_byte(8'h42);
    bus_read(RX_A, 1'b0, 8'h00, "rx41");
    bus_read(RX_A, 1'b0, 8'h00, "rx42");
    bus_read(RX_A, 1'b0, 8'h00, "rx_empty");
    bus_read(LSR_A, 1'b0, 8'h00, "lsr_empty");

    // One byte more than fits: overrun reported once, 0x10 lost.
    for (int i = 0; i <= 16; i++) push_byte(8'(i));
    bus_read(LSR_A, 1'b0, 8'h00, "lsr_ovr");
    check("lsr_ovr.bits", {30'b0, bus.rdata[9:8]}, 32'd3);
    bus_read(LSR_A, 1'b0, 8'h00, "lsr_ovr_clr");
    for (int i = 0; i < 16; i++) bus_read(RX_A, 1'b0, 8'h00, "rx_full_drain");
    bus_read(RX_A, 1'b0, 8'h00, "rx_after_drain");

    // Full FIFO: push during a pop is accepted and is not an overrun.
    for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i));
    bus_read(RX_A, 1'b1, 8'hAA, "rx_full_pushpop");
    bus_read(LSR_A, 1'b0, 8'h00, "lsr_no_ovr");
    for (int i = 0; i < 16; i++) bus_read(RX_A, 1'b0, 8'h00, "rx_pushpop_drain");
    check("pushpop.last", bus.rdata, 32'h0000_00AA);

    // Push while reading an empty FIFO: all-ones returned, byte kept.
    bus_read(RX_A, 1'b1, 8'h5C, "rx_empty_push");
    bus_read(RX_A, 1'b0, 8'h00, "rx_empty_push_kept");

`ifdef UART_RX_FIFO_IRQ_EN
    for (int i = 0; i < 3; i++) push_byte(8'(8'h30 + i));
    step();
    check_irq("irq_below");
    push_byte(8'h33);
    step();
    check_irq("irq_level");
    bus_read(RX_A, 1'b0, 8'h00, "irq_pop");
    check_irq("irq_after_pop");
`endif

    // Writes are not selected and leave the FIFO alone.
    push_byte(8'h77);
    bus.valid = 1'b1;
    bus.addr  = RX_A;
    bus.wstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("write.ready", {31'b0, bus.ready}, 32'd0);
    end
    bus.valid = 1'b0;
    bus.wstrb = 4'h0;
    bus_read(LSR_A, 1'b0, 8'h00, "write.lsr");

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int op;
      op      = int'($urandom_range(0, 3));
      tx_busy = 1'($urandom_range(0, 1));
      case (op)
        0: push_byte(8'($urandom));
        1: bus_read(RX_A, 1'($urandom_range(0, 1)), 8'($urandom), "rand_rx");
        2: bus_read(LSR_A, 1'($urandom_range(0, 1)), 8'($urandom), "rand_lsr");
        default: begin
          step();
`ifdef UART_RX_FIFO_IRQ_EN
          check_irq("rand_irq");
`endif
        end
      endcase
    end
    tx_busy = 1'b0;

    // Asynchronous reset with bytes queued and a response in flight.
    while (mq.size() > 0) bus_read(RX_A, 1'b0, 8'h00, "pre_reset_drain");
    for (int i = 0; i < 5; i++) push_byte(8'(8'hE0 + i));
    bus.valid = 1'b1;
    bus.addr  = RX_A;
    step();
    check("midrst.ready_before", {31'b0, bus.ready}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("midrst.ready", {31'b0, bus.ready}, 32'd0);
    check("midrst.rdata", bus.rdata, 32'd0);
    bus.valid = 1'b0;
    mq.delete();
    m_ovr = 1'b0;
    #3 resetn = 1'b1;
    step();
    bus_read(LSR_A, 1'b0, 8'h00, "midrst.lsr");
    bus_read(RX_A, 1'b0, 8'h00, "midrst.rx");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
